apb_mem_completer: RTL

//  APB completer (slave) fronting a word-addressed register memory; answers the APB controller's

---
 rtl/apb_mem_completer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/apb_mem_completer.sv
`default_nettype none
// ============================================================================
//  Module      : apb_mem_completer
//  Description : APB completer fronting a word-addressed register memory.
//                Latches the transfer in SETUP, inserts WAIT_STATES wait
//                cycles, then completes with a registered PREADY, read data
//                and (optionally) PSLVERR for out-of-range addresses.
//                Optional feature macro: APB_COMPLETER_SLVERR_EN
//                (defined: out-of-range accesses report PSLVERR=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_mem_completer #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_PSEL,
    input  logic                  i_PENABLE,
    input  logic                  i_PWRITE,
    input  logic [ADDR_WIDTH-1:0] i_PADDR,
    input  logic [DATA_WIDTH-1:0] i_PWDATA,
    output logic                  o_PREADY,
    output logic [DATA_WIDTH-1:0] o_PRDATA,
    output logic                  o_PSLVERR
);

    localparam int                c_IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_WAIT   = 2'd1;
    localparam logic [1:0] c_ACCESS = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic                  r_in_range;
    logic [c_IDX_W-1:0]    r_idx;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0] w_idx_full;
    logic [c_IDX_W-1:0]    w_idx;
    logic                  w_in_range;
    logic                  w_setup;
    logic                  w_enter_access;
    logic                  w_complete;
    logic                  w_acc_write;
    logic                  w_acc_in_range;
    logic [c_IDX_W-1:0]    w_acc_idx;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_err;
    logic                  w_pready_nxt;
    logic [DATA_WIDTH-1:0] w_prdata_nxt;
    logic                  w_pslverr_nxt;
    logic                  w_mem_we;

    // Address decode: offset from BASE_ADDR, in range only above the base and below the depth
    assign w_idx_full = i_PADDR - BASE_ADDR;
    assign w_idx      = w_idx_full[c_IDX_W-1:0];
    assign w_in_range = (i_PADDR >= BASE_ADDR) && ({1'b0, w_idx_full} < c_DEPTH);

    assign w_setup    = i_PSEL && !i_PENABLE;
    assign w_complete = (r_state == c_ACCESS) && i_PSEL && i_PENABLE && o_PREADY;

    // Zero-wait transfers enter ACCESS straight from IDLE, so use the live decode there
    assign w_acc_write    = (r_state == c_IDLE) ? i_PWRITE   : r_write;
    assign w_acc_in_range = (r_state == c_IDLE) ? w_in_range : r_in_range;
    assign w_acc_idx      = (r_state == c_IDLE) ? w_idx      : r_idx;
    assign w_rd_word      = r_mem[w_acc_idx];

    assign w_enter_access = ((r_state == c_IDLE) && w_setup && (WAIT_STATES == 0)) ||
                            ((r_state == c_WAIT) && i_PSEL && (r_cnt == 4'd1));

`ifdef APB_COMPLETER_SLVERR_EN
    assign w_err = !w_acc_in_range;
`else
    assign w_err = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; dropping PSEL mid-transfer aborts back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_setup) begin
                    w_state_nxt = (WAIT_STATES == 0) ? c_ACCESS : c_WAIT;
                end
            end
            c_WAIT: begin
                if (!i_PSEL) begin
                    w_state_nxt = c_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (!i_PSEL || w_complete) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Output logic: next values of the registered response and the memory write strobe
    always_comb begin
        w_pready_nxt  = o_PREADY;
        w_prdata_nxt  = o_PRDATA;
        w_pslverr_nxt = o_PSLVERR;
        w_mem_we      = 1'b0;
        if (w_enter_access) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_err;
            if (!w_acc_write) begin
                w_prdata_nxt = w_acc_in_range ? w_rd_word : '0;
            end
        end else if ((r_state != c_IDLE) && (w_state_nxt == c_IDLE)) begin
            w_pready_nxt  = 1'b0;
            w_pslverr_nxt = 1'b0;
            w_mem_we      = w_complete && r_write && r_in_range;
        end
    end

    // Registered response outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_PREADY  <= 1'b0;
            o_PRDATA  <= '0;
            o_PSLVERR <= 1'b0;
        end else begin
            o_PREADY  <= w_pready_nxt;
            o_PRDATA  <= w_prdata_nxt;
            o_PSLVERR <= w_pslverr_nxt;
        end
    end

    // Transfer latch in SETUP and wait-state countdown
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= 4'd0;
            r_write    <= 1'b0;
            r_in_range <= 1'b0;
            r_idx      <= '0;
        end else if ((r_state == c_IDLE) && w_setup) begin
            r_cnt      <= 4'(WAIT_STATES);
            r_write    <= i_PWRITE;
            r_in_range <= w_in_range;
            r_idx      <= w_idx;
        end else if (r_state == c_WAIT) begin
            r_cnt      <= r_cnt - 4'd1;
        end
    end

    // Memory array; written only on the completion edge of an in-range write
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_mem_we) begin
            r_mem[r_idx] <= i_PWDATA;
        end
    end

endmodule
`default_nettype wire
